scan_addr_gen: RTL and testbench
================================

Name: scan_addr_gen

Overview:
- Upstream stage for decoder_3_8: generates the 3-bit select A that drives the decoder, stepping through all addresses with a programmable dwell per address.
- Supports single-shot or continuous scanning, up or down direction, and start/stop control.
- Its output addr_out connects directly to decoder_3_8 input A; addr_valid qualifies it for downstream logic that samples the decoder's Y.

Parameters:
- ADDR_W, 3, width of the generated address; the scan range is 0 to 2**ADDR_W-1.
- DWELL_W, 8, width of the dwell count input.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a scan; sampled only in IDLE.
- stop  input  1  abort the scan; sampled in RUN and IDLE.
- continuous  input  1  1 = wrap and repeat; 0 = single pass. Latched on accepted start.
- dir_down  input  1  0 = count up from 0; 1 = count down from max. Latched on accepted start.
- dwell  input  DWELL_W  extra hold cycles per address. Each address is held dwell+1 cycles. Latched on accepted start.
- addr_out  output  ADDR_W  registered address to the decoder.
- addr_valid  output  1  high while addr_out is a live scan address.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a single-shot pass completes.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, addr_out=0, addr_valid=0, busy=0, done=0, dwell counter=0, latched configuration=0. Reset asserted mid-scan aborts immediately with no done pulse.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE, start=1 and stop=0:
  - Latch continuous, dir_down and dwell.
  - addr_out = dir_down ? 2**ADDR_W-1 : 0.
  - dwell counter = dwell; next state RUN.
  - addr_valid and busy go high on the cycle after start is sampled (1-cycle latency).
- IDLE, start=1 and stop=1: stop wins, start is ignored, state stays IDLE.
- RUN, stop=1: next state IDLE, addr_valid=0, busy=0, no done pulse, addr_out holds its last value.
- RUN, stop=0, counter>0: counter decrements; addr_out holds.
- RUN, stop=0, counter==0, addr_out not last (last = max when up, 0 when down): addr_out steps ±1 and the counter reloads with the latched dwell.
- RUN, stop=0, counter==0, addr_out is last:
  - If continuous=1: wrap to 0 (up) or max (down), reload counter, stay in RUN. No done pulse and no gap in addr_valid.
  - If continuous=0: next state DONE; addr_valid=0, done=1, busy=1 for that one cycle.
- DONE: unconditionally returns to IDLE next cycle; done and busy drop. Start in DONE is ignored.
- Start asserted in RUN or DONE is ignored; changes to config inputs during RUN have no effect.
- Arithmetic: address stepping is modulo 2**ADDR_W; the dwell counter is an unsigned DWELL_W down-counter with no underflow.
- dwell=0 gives one cycle per address. A full single-shot pass lasts 2**ADDR_W*(dwell+1) cycles of addr_valid.

Optional Feature:
- Macro: SCAN_ADDR_GEN_PAUSE_EN.
- With the macro defined:
  - Adds input pause (1 bit). In RUN with pause=1 and stop=0, the counter, addr_out and state all freeze; addr_valid stays high.
  - stop overrides pause.
  - pause has no effect in IDLE or DONE.
- Without the macro: the port is absent and behaviour is exactly as above.

Decomposition:
- Package scan_pkg holds:
  - The state enum scan_state_e {IDLE, RUN, DONE}.
  - Default constants SCAN_ADDR_W=3 and SCAN_DWELL_W=8.
- One sub-module: scan_dwell_timer, a loadable DWELL_W down-counter with load, enable and a zero flag, instantiated once.
- The FSM and address register stay in scan_addr_gen.

Test Plan:
- Reset, then start with dwell=0, up, single-shot -> addr_out 0,1,...,7 on 8 consecutive cycles with addr_valid=1; done=1 on the next cycle; busy low the cycle after that.
- dwell=2, dir_down=1, single-shot -> each of 7..0 held 3 cycles (24 valid cycles total); done pulses once.
- continuous=1, dwell=0, up -> sequence 7 followed immediately by 0 with no addr_valid gap; stop at addr 3 -> next cycle addr_valid=0, busy=0, addr_out=3, done never asserted.
- start and stop high together in IDLE -> stays IDLE; start during RUN with a different dwell -> ignored, original timing kept.
- rst_n driven low asynchronously mid-scan at addr 5 -> outputs clear immediately without waiting for a clock edge; no done pulse.
- With SCAN_ADDR_GEN_PAUSE_EN: pause for 4 cycles at addr 2 with dwell=0 -> addr 2 held 5 cycles total; then 3 follows.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and default sizes for the decoder address scanner.
// State encoding is fixed so the FSM can use plain logic constants.
package scan_pkg;
  localparam int SCAN_ADDR_W  = 3;
  localparam int SCAN_DWELL_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } scan_state_e;
endpackage

// File: rtl/scan_dwell_timer.sv
// Loadable down-counter timing how long each scan address is held.
// Latency: load/decrement visible the cycle after; zero flag is decoded from the register.
// Backpressure: none; en freezes the count, load always wins over en.
module scan_dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);
endmodule

// File: rtl/scan_addr_gen.sv
// Address scanner driving decoder_3_8 select A; each address held dwell+1 cycles.
// Latency: outputs registered, addr_valid/busy rise one cycle after an accepted start.
// Backpressure: stop aborts; SCAN_ADDR_GEN_PAUSE_EN adds a pause input that freezes RUN.
module scan_addr_gen
  import scan_pkg::*;
#(
  parameter int ADDR_W  = SCAN_ADDR_W,
  parameter int DWELL_W = SCAN_DWELL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic               dir_down,
  input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_ADDR_GEN_PAUSE_EN
  input  logic               pause,
`endif
  output logic [ADDR_W-1:0]  addr_out,
  output logic               addr_valid,
  output logic               busy,
  output logic               done
);
  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_RUN  = 2'(RUN);
  localparam logic [1:0] ST_DONE = 2'(DONE);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  logic [1:0]         state;
  logic               cont_q;
  logic               dir_q;
  logic [DWELL_W-1:0] dwell_q;

  logic               hold;
  logic               start_ok;
  logic               run_go;
  logic               at_last;
  logic [ADDR_W-1:0]  addr_step;
  logic               tmr_load;
  logic               tmr_en;
  logic               tmr_zero;
  logic [DWELL_W-1:0] tmr_val;

`ifdef SCAN_ADDR_GEN_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign start_ok  = (state == ST_IDLE) && start && !stop;
  assign run_go    = (state == ST_RUN) && !stop && !hold;
  assign at_last   = dir_q ? (addr_out == '0) : (addr_out == ADDR_MAX);
  // Modulo stepping makes the continuous wrap the same operation as a normal step.
  assign addr_step = dir_q ? (addr_out - ADDR_W'(1)) : (addr_out + ADDR_W'(1));

  assign tmr_load = start_ok || (run_go && tmr_zero && (!at_last || cont_q));
  assign tmr_val  = start_ok ? dwell : dwell_q;
  assign tmr_en   = run_go && !tmr_zero;

  scan_dwell_timer #(.W(DWELL_W)) u_dwell_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cont_q     <= 1'b0;
      dir_q      <= 1'b0;
      dwell_q    <= '0;
      addr_out   <= '0;
      addr_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done       <= 1'b0;
          addr_valid <= 1'b0;
          busy       <= 1'b0;
          if (start_ok) begin
            cont_q     <= continuous;
            dir_q      <= dir_down;
            dwell_q    <= dwell;
            addr_out   <= dir_down ? ADDR_MAX : '0;
            addr_valid <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            // Abort keeps addr_out so the last decoded line is still observable.
            state      <= ST_IDLE;
            addr_valid <= 1'b0;
            busy       <= 1'b0;
          end else if (!hold && tmr_zero) begin
            if (!at_last || cont_q) begin
              addr_out <= addr_step;
            end else begin
              state      <= ST_DONE;
              addr_valid <= 1'b0;
              done       <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          addr_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_scan_addr_gen.sv
// Bench for scan_addr_gen: vector table of scan configurations plus hand sequences
// for continuous wrap/stop, start+stop collision, async reset and (optionally) pause.
module tb_scan_addr_gen;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       continuous;
  logic       dir_down;
  logic [7:0] dwell;
`ifdef SCAN_ADDR_GEN_PAUSE_EN
  logic       pause;
`endif
  logic [2:0] addr_out;
  logic       addr_valid;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0] addr;
    logic       vld;
    logic       bsy;
    logic       dn;
  } exp_t;

  typedef struct {
    logic       cont;
    logic       dir;
    logic [7:0] dw;
    int         poke;
  } vec_t;

  exp_t q[$];
  vec_t vt[4];

  scan_addr_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .dir_down   (dir_down),
    .dwell      (dwell),
`ifdef SCAN_ADDR_GEN_PAUSE_EN
    .pause      (pause),
`endif
    .addr_out   (addr_out),
    .addr_valid (addr_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] a, input logic v, input logic b, input logic d);
    exp_t e;
    e.addr = a;
    e.vld  = v;
    e.bsy  = b;
    e.dn   = d;
    q.push_back(e);
  endtask

  // Expected single-shot pass straight from the behavioural description.
  task automatic build_single(input logic dir, input int dw);
    logic [2:0] a;
    for (int k = 0; k < 8; k++) begin
      a = dir ? 3'(7 - k) : 3'(k);
      for (int r = 0; r <= dw; r++) push(a, 1'b1, 1'b1, 1'b0);
    end
    a = dir ? 3'd0 : 3'd7;
    push(a, 1'b0, 1'b1, 1'b1);
    push(a, 1'b0, 1'b0, 1'b0);
    push(a, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start_scan(input logic c, input logic d, input logic [7:0] w);
    continuous = c;
    dir_down   = d;
    dwell      = w;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // One queue entry is compared per cycle at the falling edge; hooks poke inputs mid-run.
  task automatic run_check(input string tag, input int poke_idx, input int stop_idx,
                           input int pause_on, input int pause_off);
    exp_t e;
    int   n;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = q.pop_front();
      chk($sformatf("%s addr #%0d", tag, i), int'(addr_out), int'(e.addr));
      chk($sformatf("%s valid #%0d", tag, i), int'(addr_valid), int'(e.vld));
      chk($sformatf("%s busy #%0d", tag, i), int'(busy), int'(e.bsy));
      chk($sformatf("%s done #%0d", tag, i), int'(done), int'(e.dn));
      if (i == poke_idx) begin
        start      = 1'b1;
        dwell      = 8'd5;
        dir_down   = ~dir_down;
        continuous = ~continuous;
      end
      if (i == poke_idx + 1) start = 1'b0;
      if (i == stop_idx) stop = 1'b1;
      if (i == stop_idx + 1) stop = 1'b0;
`ifdef SCAN_ADDR_GEN_PAUSE_EN
      if (i == pause_on) pause = 1'b1;
      if (i == pause_off) pause = 1'b0;
`else
      if (pause_on >= 0 || pause_off >= 0) begin
        // Pause hooks are only meaningful when the pause port exists.
      end
`endif
    end
  endtask

  initial begin
    int found;
    rst_n      = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    continuous = 1'b0;
    dir_down   = 1'b0;
    dwell      = 8'd0;
`ifdef SCAN_ADDR_GEN_PAUSE_EN
    pause      = 1'b0;
`endif

    vt[0] = '{cont: 1'b0, dir: 1'b0, dw: 8'd0, poke: -1};
    vt[1] = '{cont: 1'b0, dir: 1'b1, dw: 8'd2, poke: -1};
    vt[2] = '{cont: 1'b0, dir: 1'b0, dw: 8'd1, poke: 3};
    vt[3] = '{cont: 1'b0, dir: 1'b1, dw: 8'd0, poke: -1};

    #2;
    chk("reset addr", int'(addr_out), 0);
    chk("reset valid", int'(addr_valid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // start and stop together: stop wins.
    stop = 1'b1;
    start_scan(1'b0, 1'b0, 8'd0);
    stop = 1'b0;
    push(3'd0, 1'b0, 1'b0, 1'b0);
    push(3'd0, 1'b0, 1'b0, 1'b0);
    push(3'd0, 1'b0, 1'b0, 1'b0);
    run_check("start+stop", -1, -1, -1, -1);

    foreach (vt[v]) begin
      build_single(vt[v].dir, int'(vt[v].dw));
      start_scan(vt[v].cont, vt[v].dir, vt[v].dw);
      run_check($sformatf("vec%0d", v), vt[v].poke, -1, -1, -1);
    end

    // Continuous up: 7 wraps straight to 0, then stop while on address 3.
    for (int k = 0; k < 12; k++) push(3'(k), 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) push(3'd3, 1'b0, 1'b0, 1'b0);
    start_scan(1'b1, 1'b0, 8'd0);
    run_check("cont", -1, 11, -1, -1);

    // Asynchronous reset mid-scan at address 5.
    start_scan(1'b1, 1'b0, 8'd1);
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (addr_out == 3'd5 && addr_valid) begin
        found = 1;
        break;
      end
    end
    chk("reach addr5", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst addr", int'(addr_out), 0);
    chk("arst valid", int'(addr_valid), 0);
    chk("arst busy", int'(busy), 0);
    chk("arst done", int'(done), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("arst hold done #%0d", k), int'(done), 0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) push(3'd0, 1'b0, 1'b0, 1'b0);
    run_check("post-arst", -1, -1, -1, -1);

`ifdef SCAN_ADDR_GEN_PAUSE_EN
    // Pause four cycles on address 2: it is held five cycles in total.
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < ((k == 2) ? 5 : 1); r++) push(3'(k), 1'b1, 1'b1, 1'b0);
    end
    push(3'd7, 1'b0, 1'b1, 1'b1);
    push(3'd7, 1'b0, 1'b0, 1'b0);
    start_scan(1'b0, 1'b0, 8'd0);
    run_check("pause", -1, -1, 2, 6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
